// File: rtl/imul_int_mul_var_if.sv
// Request/response stream bundle for the iterative multiplier.
// Request message: {op[1:0], a[NBITS-1:0], b[NBITS-1:0]}; response message: NBITS result.
interface imul_int_mul_var_if #(
    parameter int NBITS = 32
);
    logic               istream_val;
    logic               istream_rdy;
    logic [2*NBITS+1:0] istream_msg;
    logic               ostream_val;
    logic               ostream_rdy;
    logic [NBITS-1:0]   ostream_msg;

    modport master (
        output istream_val, istream_msg, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg
    );

    modport slave (
        input  istream_val, istream_msg, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg
    );
endinterface

// File: rtl/imul_int_mul_var.sv
// Iterative shift-add multiplier supporting MUL/MULH/MULHU/MULHSU on NBITS operands,
// with optional early exit once the remaining multiplier bits are all zero.
module imul_int_mul_var #(
    parameter int NBITS      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    imul_int_mul_var_if.slave   io
);
    localparam int CW = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU} op_t;

    state_t               r_state;
    state_t               w_state_next;
    op_t                  r_op;
    logic                 r_neg;
    logic [2*NBITS-1:0]   r_mcand;
    logic [2*NBITS-1:0]   r_acc;
    logic [NBITS-1:0]     r_mplier;
    logic [NBITS-1:0]     r_msg;
    logic [CW-1:0]        r_cnt;

    op_t                  w_op;
    logic [NBITS-1:0]     w_a;
    logic [NBITS-1:0]     w_b;
    logic                 w_sa;
    logic                 w_sb;
    logic [NBITS-1:0]     w_abs_a;
    logic [NBITS-1:0]     w_abs_b;
    logic [2*NBITS-1:0]   w_acc_next;
    logic [NBITS-1:0]     w_mplier_next;
    logic [CW-1:0]        w_cnt_next;
    logic                 w_last;
    logic [2*NBITS-1:0]   w_prod;
    logic [NBITS-1:0]     w_result;

    assign w_op = op_t'(io.istream_msg[2*NBITS+1:2*NBITS]);
    assign w_a  = io.istream_msg[2*NBITS-1:NBITS];
    assign w_b  = io.istream_msg[NBITS-1:0];

    // Sign-magnitude preparation: the most-negative value negates to 2^(N-1), which is
    // exactly right when the magnitude is treated as unsigned.
    assign w_sa    = ((w_op == OP_MULH) || (w_op == OP_MULHSU)) && w_a[NBITS-1];
    assign w_sb    = (w_op == OP_MULH) && w_b[NBITS-1];
    assign w_abs_a = w_sa ? -w_a : w_a;
    assign w_abs_b = w_sb ? -w_b : w_b;

    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;
    assign w_cnt_next    = r_cnt + CW'(1);
    assign w_last        = (w_cnt_next == CW'(NBITS)) ||
                           (EARLY_EXIT && (w_mplier_next == '0));

    assign w_prod   = r_neg ? -w_acc_next : w_acc_next;
    assign w_result = (r_op == OP_MUL) ? w_prod[NBITS-1:0] : w_prod[2*NBITS-1:NBITS];

    assign io.ostream_msg = r_msg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        io.istream_rdy = 1'b0;
        io.ostream_val = 1'b0;
        case (r_state)
            IDLE: begin
                io.istream_rdy = 1'b1;
                if (io.istream_val) begin
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                io.ostream_val = 1'b1;
                if (io.ostream_rdy) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_msg    <= '0;
        end else if ((r_state == IDLE) && io.istream_val) begin
            r_op     <= w_op;
            r_neg    <= w_sa ^ w_sb;
            r_mcand  <= {{NBITS{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == CALC) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*NBITS-2:0], 1'b0};
            r_mplier <= w_mplier_next;
            r_cnt    <= w_cnt_next;
            // Result is finalised from the last iteration's sum so DONE presents it directly.
            if (w_last) begin
                r_msg <= w_result;
            end
        end
    end
endmodule

// File: tb/tb_imul_int_mul_var.sv
// Directed and random checks of imul_int_mul_var at NBITS=32 and NBITS=8, both EARLY_EXIT settings.
module tb_imul_int_mul_var;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_val  [4];
    logic        out_rdy [4];
    logic        in_rdy  [4];
    logic        out_val [4];
    logic [31:0] out_msg [4];
    logic [65:0] msg32 = '0;
    logic [17:0] msg8  = '0;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    imul_int_mul_var_if #(.NBITS(32)) if0 ();
    imul_int_mul_var_if #(.NBITS(32)) if1 ();
    imul_int_mul_var_if #(.NBITS(8))  if2 ();
    imul_int_mul_var_if #(.NBITS(8))  if3 ();

    imul_int_mul_var #(.NBITS(32), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .reset(reset), .io(if0.slave));
    imul_int_mul_var #(.NBITS(32), .EARLY_EXIT(1'b1)) u1 (.clk(clk), .reset(reset), .io(if1.slave));
    imul_int_mul_var #(.NBITS(8),  .EARLY_EXIT(1'b0)) u2 (.clk(clk), .reset(reset), .io(if2.slave));
    imul_int_mul_var #(.NBITS(8),  .EARLY_EXIT(1'b1)) u3 (.clk(clk), .reset(reset), .io(if3.slave));

    assign if0.istream_val = in_val[0];
    assign if1.istream_val = in_val[1];
    assign if2.istream_val = in_val[2];
    assign if3.istream_val = in_val[3];
    assign if0.ostream_rdy = out_rdy[0];
    assign if1.ostream_rdy = out_rdy[1];
    assign if2.ostream_rdy = out_rdy[2];
    assign if3.ostream_rdy = out_rdy[3];
    assign if0.istream_msg = msg32;
    assign if1.istream_msg = msg32;
    assign if2.istream_msg = msg8;
    assign if3.istream_msg = msg8;

    assign in_rdy[0]  = if0.istream_rdy;
    assign in_rdy[1]  = if1.istream_rdy;
    assign in_rdy[2]  = if2.istream_rdy;
    assign in_rdy[3]  = if3.istream_rdy;
    assign out_val[0] = if0.ostream_val;
    assign out_val[1] = if1.ostream_val;
    assign out_val[2] = if2.ostream_val;
    assign out_val[3] = if3.ostream_val;
    assign out_msg[0] = if0.ostream_msg;
    assign out_msg[1] = if1.ostream_msg;
    assign out_msg[2] = {24'b0, if2.ostream_msg};
    assign out_msg[3] = {24'b0, if3.ostream_msg};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gold8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = (op == 2'd1 || op == 2'd3) ? longint'($signed(a)) : longint'({56'b0, a});
        sb = (op == 2'd1) ? longint'($signed(b)) : longint'({56'b0, b});
        p  = sa * sb;
        return (op == 2'd0) ? p[7:0] : p[15:8];
    endfunction

    task automatic send(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_rdy[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("timeout_in_rdy", 64'(in_rdy[d]), 64'd1);
        if (d < 2) msg32 = {op, a, b};
        else       msg8  = {op, a[7:0], b[7:0]};
        in_val[d] = 1'b1;
        @(posedge clk); #1;
        in_val[d] = 1'b0;
    endtask

    task automatic recv(input int d, output logic [31:0] msg, output int lat);
        int n = 0;
        while (!out_val[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("timeout_out_val", 64'(out_val[d]), 64'd1);
        lat = n + 1;
        msg = out_msg[d];
        out_rdy[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic op_chk(input int d, input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] msg;
        int          lat;
        send(d, op, a, b);
        recv(d, msg, lat);
        check(tag, 64'(msg), 64'(exp));
        if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic rand_stream(input int d);
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  exp;
        logic [31:0] msg;
        int          n;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            op  = 2'($urandom_range(0, 3));
            a   = 8'($urandom);
            b   = 8'($urandom);
            exp = gold8(op, a, b);
            send(d, op, {24'b0, a}, {24'b0, b});
            n = 0;
            // Garbage requests and early ostream_rdy while busy must be ignored.
            while (!out_val[d] && n < 100) begin
                in_val[d]  = 1'($urandom_range(0, 1));
                msg8       = 18'($urandom);
                out_rdy[d] = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end
            in_val[d]  = 1'b0;
            out_rdy[d] = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            recv(d, msg, n);
            check("rand8", 64'(msg), 64'(exp));
        end
    endtask

    initial begin
        logic [31:0] held;
        int          seen;
        for (int i = 0; i < 4; i++) begin
            in_val[i]  = 1'b0;
            out_rdy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rst_in_rdy",  64'(in_rdy[i]),  64'd1);
            check("rst_out_val", 64'(out_val[i]), 64'd0);
            check("rst_out_msg", 64'(out_msg[i]), 64'd0);
        end

        // NBITS=32 fixed latency
        op_chk(0, "f32_mul_3x4",   2'd0, 32'd3,          32'd4,          32'h0000000C, 33);
        op_chk(0, "f32_mul_neg2x3",2'd0, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA, 33);
        op_chk(0, "f32_mulh_min",  2'd1, 32'h80000000,   32'h80000000,   32'h40000000, 33);
        op_chk(0, "f32_mulh_m1",   2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 33);
        op_chk(0, "f32_mulhu",     2'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33);
        op_chk(0, "f32_mulhsu",    2'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 33);

        // NBITS=32 early exit
        op_chk(1, "e32_mul_3x4",   2'd0, 32'd3,          32'd4,          32'h0000000C, 4);
        op_chk(1, "e32_mul_7x0",   2'd0, 32'd7,          32'd0,          32'h00000000, 2);
        op_chk(1, "e32_mul_neg2x3",2'd0, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFA, 3);
        op_chk(1, "e32_mulh_min",  2'd1, 32'h80000000,   32'h80000000,   32'h40000000, 33);
        op_chk(1, "e32_mulh_m1",   2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 2);
        op_chk(1, "e32_mulhu",     2'd2, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33);
        op_chk(1, "e32_mulhsu",    2'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF, 33);

        // Backpressure with a second request queued during DONE
        out_rdy[1] = 1'b0;
        send(1, 2'd0, 32'h10, 32'h10);
        seen = 0;
        while (!out_val[1] && seen < 100) begin
            @(posedge clk); #1;
            seen++;
        end
        held = out_msg[1];
        check("bp_first_msg", 64'(held), 64'h100);
        msg32     = {2'd0, 32'd5, 32'd6};
        in_val[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_msg_stable", 64'(out_msg[1]), 64'(held));
            check("bp_val_held",   64'(out_val[1]), 64'd1);
            check("bp_in_rdy_low", 64'(in_rdy[1]),  64'd0);
        end
        out_rdy[1] = 1'b1;
        @(posedge clk); #1;
        check("bp_rdy_after", 64'(in_rdy[1]),  64'd1);
        check("bp_val_after", 64'(out_val[1]), 64'd0);
        @(posedge clk); #1;
        in_val[1] = 1'b0;
        recv(1, held, seen);
        check("bp_second_5x6", 64'(held), 64'h1E);

        // Reset five cycles into CALC
        send(1, 2'd0, 32'h1234, 32'h5678);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("mrst_in_rdy",  64'(in_rdy[1]),  64'd1);
        check("mrst_out_val", 64'(out_val[1]), 64'd0);
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_val[1]) seen++;
        end
        check("mrst_no_result", 64'(seen), 64'd0);
        op_chk(1, "mrst_mul_2x2", 2'd0, 32'd2, 32'd2, 32'h4, 3);

        // NBITS=8
        op_chk(2, "f8_mulhu_ff", 2'd2, 32'hFF, 32'hFF, 32'hFE, 9);
        op_chk(2, "f8_mul_ff",   2'd0, 32'hFF, 32'hFF, 32'h01, 9);
        op_chk(2, "f8_mulh",     2'd1, 32'h80, 32'h7F, 32'hC0, 9);
        op_chk(3, "e8_mulhu_ff", 2'd2, 32'hFF, 32'hFF, 32'hFE, 9);
        op_chk(3, "e8_mul_ff",   2'd0, 32'hFF, 32'hFF, 32'h01, 9);
        op_chk(3, "e8_mulh",     2'd1, 32'h80, 32'h7F, 32'hC0, 8);

        rand_stream(2);
        rand_stream(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
